// File: rtl/mmio_io_pkg.sv
// mmio_io_pkg
// Shared definitions for the memory-mapped I/O controller. It holds:
//   - the register offsets from BASE
//   - the bit positions inside a KCTRL/SCTRL status word
//   - the read value returned for unmapped addresses
//   - the decoded register-select enum
//   - the status-register type, with its next-state and read-word helpers
package mmio_io_pkg;

    localparam logic [11:0] OFS_HEX   = 12'h000;
    localparam logic [11:0] OFS_LEDR  = 12'h004;
    localparam logic [11:0] OFS_LEDG  = 12'h008;
    localparam logic [11:0] OFS_KDATA = 12'h010;
    localparam logic [11:0] OFS_SDATA = 12'h014;
    localparam logic [11:0] OFS_KCTRL = 12'h110;
    localparam logic [11:0] OFS_SCTRL = 12'h114;

    localparam int CTRL_READY = 0;
    localparam int CTRL_OVR   = 2;
    localparam int CTRL_IE    = 8;

    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_HEX,
        SEL_LEDR,
        SEL_LEDG,
        SEL_KDATA,
        SEL_SDATA,
        SEL_KCTRL,
        SEL_SCTRL
    } reg_sel_e;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic ready;
    } ctrl_t;

    // Compute the next status value from one edge's events.
    // Priorities:
    //   - A new stable value sets ready, even when the data register is read
    //     on the same edge.
    //   - A new stable value that arrives while the previous one is still
    //     unread sets overrun. This wins over a clear written on the same edge.
    //   - If the data register is read on that same edge, the old value was
    //     consumed, so it does not count as an overrun.
    function automatic ctrl_t ctrl_next(input ctrl_t cur,
                                        input logic  update,
                                        input logic  data_rd,
                                        input logic  ctrl_we,
                                        input logic  wr_ovr,
                                        input logic  wr_ie);
        ctrl_t nxt;
        nxt = cur;
        if (ctrl_we) begin
            nxt.ie = wr_ie;
            if (!wr_ovr) begin
                nxt.ovr = 1'b0;
            end
        end
        if (update && cur.ready && !data_rd) begin
            nxt.ovr = 1'b1;
        end
        if (data_rd) begin
            nxt.ready = 1'b0;
        end
        if (update) begin
            nxt.ready = 1'b1;
        end
        return nxt;
    endfunction

    // Build the read view of a status register. Bits that are not defined read as 0.
    function automatic logic [8:0] ctrl_word(input ctrl_t c);
        logic [8:0] w;
        w             = '0;
        w[CTRL_READY] = c.ready;
        w[CTRL_OVR]   = c.ovr;
        w[CTRL_IE]    = c.ie;
        return w;
    endfunction

endpackage

// File: rtl/mmio_io_ctrl_debounce.sv
// io_debounce
// Synchronises and debounces an asynchronous input vector as a whole.
// The vector is accepted only after the synchronised value has held steady
// for DEBOUNCE consecutive cycles.
// Ports:
//   clk      core clock
//   reset    asynchronous, active-high
//   raw_in   [W] asynchronous input, already polarity-corrected
//   stable   [W] debounced value
//   changed  high in the cycle whose rising edge loads a new value into stable
module io_debounce #(
    parameter int          W        = 4,
    parameter int unsigned DEBOUNCE = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw_in,
    output logic [W-1:0] stable,
    output logic         changed
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [W-1:0]  sync1;
    logic [W-1:0]  sync2;
    logic [W-1:0]  prev;
    logic [CW-1:0] cnt;

    // Combinational, so the status logic in the top can set ready on the same edge that stable loads.
    assign changed = (sync2 == prev) && (sync2 != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            prev   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            prev  <= sync2;
            // A change since the last cycle means the input is still bouncing, so the count restarts.
            if (sync2 != prev) begin
                cnt <= '0;
            end else if (sync2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl
// Memory-mapped I/O block on the processor data bus.
// It owns these registers:
//   - HEX, LEDR, LEDG output registers
//   - debounced KEY/SW data registers
//   - KCTRL/SCTRL status registers (ready, overrun, interrupt enable)
// Ports:
//   clk, reset            core clock; asynchronous active-high reset
//   bus_addr, bus_wdata   byte address and write data
//   bus_we, bus_re        write and read strobes, committed at the rising clock edge
//   bus_rdata, bus_sel    combinational read data and address-hit flag
//   key_in, sw_in         raw asynchronous pins
//   hex_out, ledr_out,
//   ledg_out              output registers
//   irq                   any port that is ready with its interrupt enabled
module mmio_io_ctrl
    import mmio_io_pkg::*;
#(
    parameter int unsigned        DBITS          = 32,
    parameter logic [DBITS-1:0]   BASE           = 32'hF0000000,
    parameter int unsigned        HEXBITS        = 16,
    parameter logic [HEXBITS-1:0] HEX_RESET      = 16'hDEAD,
    parameter int unsigned        NLEDR          = 10,
    parameter int unsigned        NLEDG          = 8,
    parameter int unsigned        NKEY           = 4,
    parameter int unsigned        NSW            = 10,
    parameter bit                 KEY_ACTIVE_LOW = 1'b1,
    parameter logic [15:0]        DEBOUNCE       = 16'd50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DBITS-1:0]   bus_addr,
    input  logic               bus_we,
    input  logic               bus_re,
    input  logic [DBITS-1:0]   bus_wdata,
    output logic [DBITS-1:0]   bus_rdata,
    output logic               bus_sel,
    input  logic [NKEY-1:0]    key_in,
    input  logic [NSW-1:0]     sw_in,
    output logic [HEXBITS-1:0] hex_out,
    output logic [NLEDR-1:0]   ledr_out,
    output logic [NLEDG-1:0]   ledg_out,
    output logic               irq
);

    localparam logic [DBITS-1:0] ADDR_HEX   = BASE + DBITS'(OFS_HEX);
    localparam logic [DBITS-1:0] ADDR_LEDR  = BASE + DBITS'(OFS_LEDR);
    localparam logic [DBITS-1:0] ADDR_LEDG  = BASE + DBITS'(OFS_LEDG);
    localparam logic [DBITS-1:0] ADDR_KDATA = BASE + DBITS'(OFS_KDATA);
    localparam logic [DBITS-1:0] ADDR_SDATA = BASE + DBITS'(OFS_SDATA);
    localparam logic [DBITS-1:0] ADDR_KCTRL = BASE + DBITS'(OFS_KCTRL);
    localparam logic [DBITS-1:0] ADDR_SCTRL = BASE + DBITS'(OFS_SCTRL);

    reg_sel_e        sel;
    logic [NKEY-1:0] key_raw;
    logic [NKEY-1:0] key_stable;
    logic [NSW-1:0]  sw_stable;
    logic            key_changed;
    logic            sw_changed;
    ctrl_t           kctrl;
    ctrl_t           sctrl;
    logic            kdata_rd;
    logic            sdata_rd;
    logic            kctrl_we;
    logic            sctrl_we;
    logic            unused_wdata;

    // Upper write-data bits are intentionally dropped by the narrower registers.
    assign unused_wdata = ^bus_wdata;

    // Active-low keys are inverted before synchronisation, so a pressed key reads as 1.
    assign key_raw = KEY_ACTIVE_LOW ? ~key_in : key_in;

    io_debounce #(.W(NKEY), .DEBOUNCE(DEBOUNCE)) u_key_db (
        .clk     (clk),
        .reset   (reset),
        .raw_in  (key_raw),
        .stable  (key_stable),
        .changed (key_changed)
    );

    io_debounce #(.W(NSW), .DEBOUNCE(DEBOUNCE)) u_sw_db (
        .clk     (clk),
        .reset   (reset),
        .raw_in  (sw_in),
        .stable  (sw_stable),
        .changed (sw_changed)
    );

    // Full-width address decode. Any address that is not exactly a register address is unmapped.
    always_comb begin
        sel = SEL_NONE;
        case (bus_addr)
            ADDR_HEX:   sel = SEL_HEX;
            ADDR_LEDR:  sel = SEL_LEDR;
            ADDR_LEDG:  sel = SEL_LEDG;
            ADDR_KDATA: sel = SEL_KDATA;
            ADDR_SDATA: sel = SEL_SDATA;
            ADDR_KCTRL: sel = SEL_KCTRL;
            ADDR_SCTRL: sel = SEL_SCTRL;
            default:    sel = SEL_NONE;
        endcase
    end

    always_comb begin
        bus_rdata = DBITS'(UNMAPPED_RDATA);
        bus_sel   = 1'b1;
        case (sel)
            SEL_HEX:   bus_rdata = DBITS'(hex_out);
            SEL_LEDR:  bus_rdata = DBITS'(ledr_out);
            SEL_LEDG:  bus_rdata = DBITS'(ledg_out);
            SEL_KDATA: bus_rdata = DBITS'(key_stable);
            SEL_SDATA: bus_rdata = DBITS'(sw_stable);
            SEL_KCTRL: bus_rdata = DBITS'(ctrl_word(kctrl));
            SEL_SCTRL: bus_rdata = DBITS'(ctrl_word(sctrl));
            default:   bus_sel   = 1'b0;
        endcase
    end

    assign kdata_rd = bus_re && (sel == SEL_KDATA);
    assign sdata_rd = bus_re && (sel == SEL_SDATA);
    assign kctrl_we = bus_we && (sel == SEL_KCTRL);
    assign sctrl_we = bus_we && (sel == SEL_SCTRL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_out  <= HEX_RESET;
            ledr_out <= '0;
            ledg_out <= '0;
        end else if (bus_we) begin
            if (sel == SEL_HEX) begin
                hex_out <= bus_wdata[HEXBITS-1:0];
            end
            if (sel == SEL_LEDR) begin
                ledr_out <= bus_wdata[NLEDR-1:0];
            end
            if (sel == SEL_LEDG) begin
                ledg_out <= bus_wdata[NLEDG-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kctrl <= '0;
            sctrl <= '0;
        end else begin
            kctrl <= ctrl_next(kctrl, key_changed, kdata_rd, kctrl_we,
                               bus_wdata[CTRL_OVR], bus_wdata[CTRL_IE]);
            sctrl <= ctrl_next(sctrl, sw_changed, sdata_rd, sctrl_we,
                               bus_wdata[CTRL_OVR], bus_wdata[CTRL_IE]);
        end
    end

    assign irq = (kctrl.ie & kctrl.ready) | (sctrl.ie & sctrl.ready);

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl
// Self-checking bench for mmio_io_ctrl, built with DEBOUNCE=4.
// A behavioural model of the register map runs alongside the DUT:
//   - Each input is debounced with a sliding window of pin samples.
//   - The model is compared against every DUT output on each falling clock edge.
// Directed sequences then pin specific literal values, followed by a randomised bus/pin phase.
module tb_mmio_io_ctrl;

    localparam int DB   = 4;
    localparam int HLEN = DB + 3;

    localparam logic [31:0] A_HEX   = 32'hF0000000;
    localparam logic [31:0] A_LEDR  = 32'hF0000004;
    localparam logic [31:0] A_LEDG  = 32'hF0000008;
    localparam logic [31:0] A_KDATA = 32'hF0000010;
    localparam logic [31:0] A_SDATA = 32'hF0000014;
    localparam logic [31:0] A_KCTRL = 32'hF0000110;
    localparam logic [31:0] A_SCTRL = 32'hF0000114;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_sel;
    logic [3:0]  key_in;
    logic [9:0]  sw_in;
    logic [15:0] hex_out;
    logic [9:0]  ledr_out;
    logic [7:0]  ledg_out;
    logic        irq;

    int vector_count = 0;
    int miscompare_count = 0;
    bit check_en = 1'b0;

    mmio_io_ctrl #(.DEBOUNCE(16'd4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_sel   (bus_sel),
        .key_in    (key_in),
        .sw_in     (sw_in),
        .hex_out   (hex_out),
        .ledr_out  (ledr_out),
        .ledg_out  (ledg_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [3:0]  m_kdata;
    logic [9:0]  m_sdata;
    logic        k_rdy, k_ovr, k_ie;
    logic        s_rdy, s_ovr, s_ie;
    logic [3:0]  khist [HLEN];
    logic [9:0]  shist [HLEN];

    // Model the bus read for an address: select flag and data.
    task automatic model_read(input logic [31:0] a, output logic sel, output logic [31:0] data);
        sel = 1'b1;
        case (a)
            A_HEX:   data = {16'h0, m_hex};
            A_LEDR:  data = {22'h0, m_ledr};
            A_LEDG:  data = {24'h0, m_ledg};
            A_KDATA: data = {28'h0, m_kdata};
            A_SDATA: data = {22'h0, m_sdata};
            A_KCTRL: data = {23'h0, k_ie, 5'h0, k_ovr, 1'b0, k_rdy};
            A_SCTRL: data = {23'h0, s_ie, 5'h0, s_ovr, 1'b0, s_rdy};
            default: begin
                sel  = 1'b0;
                data = 32'hDEADBEEF;
            end
        endcase
    endtask

    // Debounce model, sliding-window form.
    //   - hist[0] is the pin sample taken at this edge.
    //   - A value is accepted once the samples two to DB+2 edges back all agree on it.
    //   - The accepted value must also differ from the currently accepted one.
    always @(posedge clk or posedge reset) begin
        logic k_upd, s_upd, k_rd, s_rd, kc_we, sc_we, n;
        logic [3:0] kv;
        logic [9:0] sv;
        if (reset) begin
            m_hex = 16'hDEAD; m_ledr = '0; m_ledg = '0;
            m_kdata = '0; m_sdata = '0;
            k_rdy = 0; k_ovr = 0; k_ie = 0;
            s_rdy = 0; s_ovr = 0; s_ie = 0;
            for (int i = 0; i < HLEN; i++) begin
                khist[i] = '0;
                shist[i] = '0;
            end
        end else begin
            for (int i = HLEN - 1; i > 0; i--) begin
                khist[i] = khist[i-1];
                shist[i] = shist[i-1];
            end
            khist[0] = ~key_in;
            shist[0] = sw_in;
            kv = khist[2];
            sv = shist[2];
            k_upd = (kv != m_kdata);
            s_upd = (sv != m_sdata);
            for (int i = 3; i < HLEN; i++) begin
                if (khist[i] != kv) k_upd = 0;
                if (shist[i] != sv) s_upd = 0;
            end
            k_rd  = bus_re && (bus_addr == A_KDATA);
            s_rd  = bus_re && (bus_addr == A_SDATA);
            kc_we = bus_we && (bus_addr == A_KCTRL);
            sc_we = bus_we && (bus_addr == A_SCTRL);

            n     = (k_upd && k_rdy && !k_rd) ? 1'b1 : ((kc_we && !bus_wdata[2]) ? 1'b0 : k_ovr);
            k_ovr = n;
            k_rdy = k_upd ? 1'b1 : (k_rd ? 1'b0 : k_rdy);
            if (kc_we) k_ie = bus_wdata[8];
            n     = (s_upd && s_rdy && !s_rd) ? 1'b1 : ((sc_we && !bus_wdata[2]) ? 1'b0 : s_ovr);
            s_ovr = n;
            s_rdy = s_upd ? 1'b1 : (s_rd ? 1'b0 : s_rdy);
            if (sc_we) s_ie = bus_wdata[8];

            if (k_upd) m_kdata = kv;
            if (s_upd) m_sdata = sv;
            if (bus_we && bus_addr == A_HEX)  m_hex  = bus_wdata[15:0];
            if (bus_we && bus_addr == A_LEDR) m_ledr = bus_wdata[9:0];
            if (bus_we && bus_addr == A_LEDG) m_ledg = bus_wdata[7:0];
        end
    end

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vector_count++;
        if (actual !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        logic        es;
        logic [31:0] er;
        if (check_en) begin
            model_read(bus_addr, es, er);
            checkOutput("model hex_out",   {16'h0, hex_out},  {16'h0, m_hex});
            checkOutput("model ledr_out",  {22'h0, ledr_out}, {22'h0, m_ledr});
            checkOutput("model ledg_out",  {24'h0, ledg_out}, {24'h0, m_ledg});
            checkOutput("model irq",       {31'h0, irq},      {31'h0, (k_ie & k_rdy) | (s_ie & s_rdy)});
            checkOutput("model bus_sel",   {31'h0, bus_sel},  {31'h0, es});
            checkOutput("model bus_rdata", bus_rdata, er);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata);
        bus_addr  = addr;
        bus_wdata = wdata;
        bus_we    = we;
        bus_re    = re;
        tick(1);
        bus_we = 1'b0;
        bus_re = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] expected);
        bus_addr = addr;
        bus_re   = 1'b0;
        #1;
        checkOutput(name, bus_rdata, expected);
    endtask

    initial begin
        bus_addr = A_KCTRL; bus_we = 0; bus_re = 0; bus_wdata = '0;
        key_in = 4'hF; sw_in = '0;
        #1 reset = 1'b1;
        check_en = 1'b1;
        tick(2);

        // Reset values
        checkOutput("reset hex_out",  {16'h0, hex_out},  32'h0000DEAD);
        checkOutput("reset ledr_out", {22'h0, ledr_out}, 32'h0);
        checkOutput("reset ledg_out", {24'h0, ledg_out}, 32'h0);
        checkOutput("reset irq",      {31'h0, irq},      32'h0);
        read_check("reset KCTRL", A_KCTRL, 32'h0);
        reset = 1'b0;
        tick(1);

        // Output registers and unmapped read
        applyStimulus(1, 0, A_HEX, 32'h00001234);
        checkOutput("hex write", {16'h0, hex_out}, 32'h00001234);
        applyStimulus(1, 0, A_LEDR, 32'hFFFFF3FF);
        checkOutput("ledr write", {22'h0, ledr_out}, 32'h000003FF);
        read_check("unmapped rdata", 32'hF0000020, 32'hDEADBEEF);
        checkOutput("unmapped sel", {31'h0, bus_sel}, 32'h0);

        // Key debounce latency: update on edge 7, not edge 6
        key_in = 4'hE;
        tick(6);
        read_check("KDATA edge 6", A_KDATA, 32'h0);
        tick(1);
        read_check("KDATA edge 7", A_KDATA, 32'h1);
        read_check("KCTRL edge 7", A_KCTRL, 32'h1);
        applyStimulus(0, 1, A_KDATA, 32'h0);

        // Bounce at edge 5 restarts the count
        key_in = 4'hF;
        tick(4);
        key_in = 4'hE;
        tick(1);
        key_in = 4'hF;
        tick(6);
        read_check("KDATA bounce held", A_KDATA, 32'h1);
        tick(1);
        read_check("KDATA bounce settled", A_KDATA, 32'h0);
        applyStimulus(0, 1, A_KDATA, 32'h0);

        // Switch overrun and its clearing
        sw_in = 10'h001;
        tick(7);
        sw_in = 10'h003;
        tick(7);
        read_check("SCTRL overrun", A_SCTRL, 32'h5);
        applyStimulus(1, 0, A_SCTRL, 32'h0);
        read_check("SCTRL ovr cleared", A_SCTRL, 32'h1);
        applyStimulus(0, 1, A_SDATA, 32'h0);
        read_check("SCTRL after read", A_SCTRL, 32'h0);
        read_check("SDATA value", A_SDATA, 32'h3);

        // Key interrupt
        applyStimulus(1, 0, A_KCTRL, 32'h100);
        key_in = 4'hE;
        tick(6);
        checkOutput("irq before update", {31'h0, irq}, 32'h0);
        tick(1);
        checkOutput("irq at update", {31'h0, irq}, 32'h1);
        applyStimulus(0, 1, A_KDATA, 32'h0);
        checkOutput("irq after read", {31'h0, irq}, 32'h0);
        key_in = 4'hF;
        tick(6);
        applyStimulus(0, 1, A_KDATA, 32'h0);
        read_check("KCTRL update+read", A_KCTRL, 32'h101);
        checkOutput("irq update+read", {31'h0, irq}, 32'h1);
        key_in = 4'hE;
        tick(6);
        applyStimulus(1, 0, A_KCTRL, 32'h0);
        read_check("KCTRL update+ovr clear", A_KCTRL, 32'h5);

        // Reset mid-debounce, then a full re-debounce
        key_in = 4'hF;
        tick(7);
        key_in = 4'hE;
        tick(5);
        reset = 1'b1;
        #1;
        read_check("KDATA in reset", A_KDATA, 32'h0);
        read_check("KCTRL in reset", A_KCTRL, 32'h0);
        checkOutput("hex in reset", {16'h0, hex_out}, 32'h0000DEAD);
        reset = 1'b0;
        tick(6);
        read_check("KDATA re-debounce edge 6", A_KDATA, 32'h0);
        tick(1);
        read_check("KDATA re-debounce edge 7", A_KDATA, 32'h1);

        // Randomised phase, checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] addrs [9];
            addrs = '{A_HEX, A_LEDR, A_LEDG, A_KDATA, A_SDATA, A_KCTRL, A_SCTRL,
                      32'hF0000020, 32'hF0000111};
            if ($urandom_range(0, 7) == 0) key_in = 4'($urandom);
            if ($urandom_range(0, 7) == 0) sw_in = 10'($urandom);
            if (i == 1500) begin
                reset = 1'b1;
                #2;
                reset = 1'b0;
            end
            applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                          addrs[$urandom_range(0, 8)], $urandom);
        end

        tick(2);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
